// File: rtl/itcm_pkg.sv
// Shared ITCM definitions: port/SRAM widths used by the IFU side and the
// SRAM operation encoding used by the controller's arbiter.
package itcm_pkg;

    localparam int ITCM_ADDR_WIDTH = 16;
    localparam int ITCM_RAM_DW     = 32;
    localparam int ITCM_RAM_AW     = ITCM_ADDR_WIDTH - 2;
    localparam int ITCM_RAM_MW     = ITCM_RAM_DW / 8;

    // What the SRAM port does in the current cycle.
    typedef enum logic [1:0] {
        RAM_IDLE  = 2'd0,
        RAM_WRITE = 2'd1,
        RAM_READ  = 2'd2
    } ram_op_e;

endpackage

// File: rtl/itcm_rsp_buf.sv
// One-entry response holding buffer. Passes the live SRAM word straight
// through when the consumer is ready and parks it when the consumer stalls,
// so a 1-cycle-latency SRAM never loses read data under back-pressure.
module itcm_rsp_buf
    import itcm_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [ITCM_RAM_DW-1:0] in_data,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [ITCM_RAM_DW-1:0] out_data,
    output logic                   hold_vld
);

    logic [ITCM_RAM_DW-1:0] hold_data;

    // Capture the live word when it is not taken; release once consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld  <= 1'b0;
            hold_data <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            if (in_valid && !out_ready) begin
                hold_vld  <= 1'b1;
                hold_data <= in_data;
            end else if (out_ready) begin
                hold_vld  <= 1'b0;
            end
        end
    end

    // The upstream never presents a new word while one is parked, so the
    // buffered word simply takes precedence.
    assign out_valid = hold_vld | in_valid;
    assign out_data  = hold_vld ? hold_data : in_data;

endmodule

// File: rtl/itcm_ctrl.sv
// Instruction TCM controller: arbitrates the loader write port (priority)
// against IFU fetches onto a single-port 1-cycle-latency SRAM and returns
// fetched words in order through a one-entry holding buffer.
module itcm_ctrl
    import itcm_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       ifu2itcm_cmd_valid,
    output logic                       ifu2itcm_cmd_ready,
    input  logic [ITCM_ADDR_WIDTH-1:0] ifu2itcm_cmd_addr,
    output logic                       ifu2itcm_rsp_valid,
    input  logic                       ifu2itcm_rsp_ready,
    output logic [ITCM_RAM_DW-1:0]     ifu2itcm_rsp_rdata,

    input  logic                       ext2itcm_cmd_valid,
    output logic                       ext2itcm_cmd_ready,
    input  logic [ITCM_ADDR_WIDTH-1:0] ext2itcm_cmd_addr,
    input  logic [ITCM_RAM_DW-1:0]     ext2itcm_cmd_wdata,
    input  logic [ITCM_RAM_MW-1:0]     ext2itcm_cmd_wmask,

    output logic                       itcm_ram_cs,
    output logic                       itcm_ram_we,
    output logic [ITCM_RAM_AW-1:0]     itcm_ram_addr,
    output logic [ITCM_RAM_MW-1:0]     itcm_ram_wem,
    output logic [ITCM_RAM_DW-1:0]     itcm_ram_din,
    input  logic [ITCM_RAM_DW-1:0]     itcm_ram_dout
);

    logic    rd_pend;
    logic    hold_vld;
    logic    buf_valid;
    logic    fetch_hs;
    ram_op_e ram_op;

    // Byte offsets inside a word carry no meaning for a word-wide TCM.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{ifu2itcm_cmd_addr[1:0], ext2itcm_cmd_addr[1:0]};

    // The loader is never stalled; a fetch needs the SRAM free and a
    // guaranteed landing slot for the word it will produce next cycle.
    assign ext2itcm_cmd_ready = 1'b1;
    assign ifu2itcm_cmd_ready = ~rst & ~ext2itcm_cmd_valid & ~hold_vld
                              & ~(rd_pend & ~ifu2itcm_rsp_ready);
    assign fetch_hs = ifu2itcm_cmd_valid & ifu2itcm_cmd_ready;

    // Pick this cycle's SRAM operation: loader write beats fetch read.
    always_comb begin
        // NOTE: a default before any condition means every path assigns the
        // signal, so no latch is inferred.
        ram_op = RAM_IDLE;
        if (!rst) begin
            if (ext2itcm_cmd_valid) ram_op = RAM_WRITE;
            else if (fetch_hs)      ram_op = RAM_READ;
        end
    end

    // Drive the SRAM pins for the chosen operation; idle pins sit at zero.
    always_comb begin
        itcm_ram_cs   = 1'b0;
        itcm_ram_we   = 1'b0;
        itcm_ram_addr = '0;
        itcm_ram_wem  = '0;
        itcm_ram_din  = '0;
        case (ram_op)
            RAM_WRITE: begin
                itcm_ram_cs   = 1'b1;
                itcm_ram_we   = 1'b1;
                itcm_ram_addr = ext2itcm_cmd_addr[ITCM_ADDR_WIDTH-1:2];
                itcm_ram_wem  = ext2itcm_cmd_wmask;
                itcm_ram_din  = ext2itcm_cmd_wdata;
            end
            RAM_READ: begin
                itcm_ram_cs   = 1'b1;
                itcm_ram_addr = ifu2itcm_cmd_addr[ITCM_ADDR_WIDTH-1:2];
            end
            default: ;
        endcase
    end

    // Remember that SRAM dout carries a fetched word in the next cycle.
    always_ff @(posedge clk) begin
        if (rst) rd_pend <= 1'b0;
        else     rd_pend <= fetch_hs;
    end

    itcm_rsp_buf u_rsp_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_pend),
        .in_data   (itcm_ram_dout),
        .out_ready (ifu2itcm_rsp_ready),
        .out_valid (buf_valid),
        .out_data  (ifu2itcm_rsp_rdata),
        .hold_vld  (hold_vld)
    );

    // A read caught by reset is dropped rather than surfaced.
    assign ifu2itcm_rsp_valid = buf_valid & ~rst;

endmodule

// File: tb/tb_itcm_ctrl.sv
// Self-checking bench for itcm_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model (word memory plus at most one outstanding reply).
module tb_itcm_ctrl;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int RAW = AW - 2;
    localparam int MW  = DW / 8;
    localparam int NW  = 1 << RAW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ifu_v = 1'b0;
    logic           ifu_ready;
    logic [AW-1:0]  ifu_addr = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [DW-1:0]  rsp_rdata;
    logic           ext_v = 1'b0;
    logic           ext_ready;
    logic [AW-1:0]  ext_addr = '0;
    logic [DW-1:0]  ext_wdata = '0;
    logic [MW-1:0]  ext_wmask = '0;
    logic           ram_cs, ram_we;
    logic [RAW-1:0] ram_addr;
    logic [MW-1:0]  ram_wem;
    logic [DW-1:0]  ram_din;
    logic [DW-1:0]  ram_dout = '0;

    itcm_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .ifu2itcm_cmd_valid (ifu_v),
        .ifu2itcm_cmd_ready (ifu_ready),
        .ifu2itcm_cmd_addr  (ifu_addr),
        .ifu2itcm_rsp_valid (rsp_valid),
        .ifu2itcm_rsp_ready (rsp_ready),
        .ifu2itcm_rsp_rdata (rsp_rdata),
        .ext2itcm_cmd_valid (ext_v),
        .ext2itcm_cmd_ready (ext_ready),
        .ext2itcm_cmd_addr  (ext_addr),
        .ext2itcm_cmd_wdata (ext_wdata),
        .ext2itcm_cmd_wmask (ext_wmask),
        .itcm_ram_cs        (ram_cs),
        .itcm_ram_we        (ram_we),
        .itcm_ram_addr      (ram_addr),
        .itcm_ram_wem       (ram_wem),
        .itcm_ram_din       (ram_din),
        .itcm_ram_dout      (ram_dout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5A5_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Physical SRAM: dout is only meaningful the cycle after a read and is
    // scrambled otherwise, so the DUT must capture it in time.
    logic [DW-1:0] sram [NW];
    always @(posedge clk) begin
        if (ram_cs && ram_we) begin
            sram[ram_addr] <= merge(sram[ram_addr], ram_din, ram_wem);
            ram_dout       <= $urandom;
        end else if (ram_cs) begin
            ram_dout <= sram[ram_addr];
        end else begin
            ram_dout <= $urandom;
        end
    end

    // Reference model: the word contents the TCM should hold, and the one
    // reply owed to the IFU (m_aged means it has already waited a cycle).
    logic [DW-1:0] m_mem [NW];
    bit            m_pend = 0;
    bit            m_aged = 0;
    logic [DW-1:0] m_data = '0;

    function automatic bit model_ready();
        return !rst && !ext_v && (!m_pend || (!m_aged && rsp_ready));
    endfunction

    always @(posedge clk) begin
        bit rdy;
        rdy = model_ready();
        if (rst) begin
            m_pend = 0;
        end else begin
            if (m_pend && rsp_ready) m_pend = 0;
            else if (m_pend)         m_aged = 1;
            if (ext_v)
                m_mem[ext_addr[AW-1:2]] = merge(m_mem[ext_addr[AW-1:2]], ext_wdata, ext_wmask);
            if (ifu_v && rdy) begin
                m_pend = 1;
                m_aged = 0;
                m_data = m_mem[ifu_addr[AW-1:2]];
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    logic           e_rdy;
    logic [5:0]     e_ctl;
    logic [RAW-1:0] e_addr;
    logic [DW-1:0]  e_din;
    bit             e_read;
    always @(negedge clk) begin
        e_rdy  = model_ready();
        e_ctl  = '0;
        e_addr = '0;
        e_din  = '0;
        e_read = 0;
        if (!rst && ext_v) begin
            e_ctl  = {1'b1, 1'b1, ext_wmask};
            e_addr = ext_addr[AW-1:2];
            e_din  = ext_wdata;
        end else if (!rst && ifu_v && e_rdy) begin
            e_ctl  = {1'b1, 1'b0, 4'h0};
            e_addr = ifu_addr[AW-1:2];
            e_read = 1;
        end
        check("cmd_ready", 32'(ifu_ready), 32'(e_rdy));
        check("ext_ready", 32'(ext_ready), 32'd1);
        check("rsp_valid", 32'(rsp_valid), 32'(!rst && m_pend));
        if (!rst && m_pend) check("rsp_rdata", rsp_rdata, m_data);
        check("ram_ctl", 32'({ram_cs, ram_we, ram_wem}), 32'(e_ctl));
        check("ram_addr", 32'(ram_addr), 32'(e_addr));
        if (!e_read) check("ram_din", ram_din, e_din);
        if (!rst) check("hold_rd_excl", 32'(dut.hold_vld & dut.rd_pend), 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [AW-1:0] a);
        ifu_v    = 1'b1;
        ifu_addr = a;
    endtask

    logic [31:0] stream_exp [3];
    logic [AW-1:0] ra;

    initial begin
        for (int i = 0; i < NW; i++) begin
            sram[i]  = init_word(i);
            m_mem[i] = init_word(i);
        end
        stream_exp[0] = 32'hA5A5_0000;
        stream_exp[1] = 32'h0050_0093;
        stream_exp[2] = 32'hA5A5_0002;

        // Reset held three cycles with a fetch pending on the port.
        fetch(16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_cs", 32'(ram_cs), 32'd0);
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        check("first_ready", 32'(ifu_ready), 32'd1);
        check("first_cs", 32'(ram_cs), 32'd1);
        step();
        ifu_v = 1'b0;
        @(negedge clk);
        check("first_rdata", rsp_rdata, 32'hA5A5_0000);
        step();

        // Load a word, then fetch it back.
        ext_v = 1'b1; ext_addr = 16'h0004; ext_wdata = 32'h0050_0093; ext_wmask = 4'hF;
        @(negedge clk);
        check("load_we", 32'(ram_we), 32'd1);
        step();
        ext_v = 1'b0;
        fetch(16'h0004);
        step();
        ifu_v = 1'b0;
        @(negedge clk);
        check("load_rsp_valid", 32'(rsp_valid), 32'd1);
        check("load_rdata", rsp_rdata, 32'h0050_0093);
        step();

        // Back-to-back stream of three fetches.
        for (int i = 0; i < 4; i++) begin
            if (i < 3) fetch(AW'(4 * i));
            else       ifu_v = 1'b0;
            @(negedge clk);
            if (i < 3) check("stream_ready", 32'(ifu_ready), 32'd1);
            if (i > 0) begin
                check("stream_valid", 32'(rsp_valid), 32'd1);
                check("stream_rdata", rsp_rdata, stream_exp[i-1]);
            end
            step();
        end

        // Back-pressure: word must stay put and no further read issues.
        fetch(16'h0008);
        step();
        rsp_ready = 1'b0;
        fetch(16'h000C);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, 32'hA5A5_0002);
            check("bp_ready", 32'(ifu_ready), 32'd0);
            check("bp_cs", 32'(ram_cs), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        ifu_v = 1'b0;
        @(negedge clk);
        check("bp_drain_rdata", rsp_rdata, 32'hA5A5_0002);
        step();
        @(negedge clk);
        check("bp_empty", 32'(rsp_valid), 32'd0);

        // Loader write lands while a read of the same word is returning.
        fetch(16'h0008);
        step();
        ext_v = 1'b1; ext_addr = 16'h0008; ext_wdata = 32'hDEAD_BEEF; ext_wmask = 4'hF;
        @(negedge clk);
        check("col_ready", 32'(ifu_ready), 32'd0);
        check("col_old_rdata", rsp_rdata, 32'hA5A5_0002);
        step();
        ext_v = 1'b0;
        @(negedge clk);
        check("col_refetch_ready", 32'(ifu_ready), 32'd1);
        step();
        ifu_v = 1'b0;
        @(negedge clk);
        check("col_new_rdata", rsp_rdata, 32'hDEAD_BEEF);
        step();

        // Reset right after a fetch handshake: the reply must vanish.
        fetch(16'h0000);
        step();
        ifu_v = 1'b0; rst = 1'b1; rsp_ready = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_after", 32'(rsp_valid), 32'd0);
            check("mid_rst_hold", 32'(dut.hold_vld), 32'd0);
            step();
        end
        rsp_ready = 1'b1;

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom % 250) == 0;
            ext_v     = ($urandom % 5) == 0;
            ifu_v     = ($urandom % 4) != 0;
            rsp_ready = ($urandom % 3) != 0;
            ra = AW'($urandom_range(0, 63));
            if ($urandom % 16 == 0) ra = AW'($urandom);
            ifu_addr = ra;
            ra = AW'($urandom_range(0, 63));
            if ($urandom % 16 == 0) ra = AW'($urandom);
            ext_addr  = ra;
            ext_wdata = $urandom;
            ext_wmask = MW'($urandom);
            step();
        end

        ifu_v = 1'b0; ext_v = 1'b0; rst = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/itcm_ctrl.md
Name: itcm_ctrl

Overview:
- Instruction TCM controller directly downstream of the IFU fetch port.
- Accepts ifu2itcm read commands, drives a single-port synchronous SRAM (1-cycle read latency) and returns 32-bit instruction words on the ifu2itcm response channel.
- A one-entry holding buffer absorbs IFU response back-pressure without losing SRAM data.
- A write-only loader port (ext2itcm) fills the TCM at boot or under debug and has priority over fetches.

Parameters:
- ITCM_ADDR_WIDTH, 16, byte-address width of the ifu2itcm and ext2itcm ports.
- ITCM_RAM_DW, 32, SRAM data width in bits (one instruction word).
- ITCM_RAM_AW, ITCM_ADDR_WIDTH-2, SRAM word-address width.

Ports:
- clk  in  1  core clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- ifu2itcm_cmd_valid  in  1  fetch request valid.
- ifu2itcm_cmd_ready  out  1  fetch request accepted.
- ifu2itcm_cmd_addr  in  ITCM_ADDR_WIDTH  fetch byte address.
- ifu2itcm_rsp_valid  out  1  instruction word valid.
- ifu2itcm_rsp_ready  in  1  IFU can take the response.
- ifu2itcm_rsp_rdata  out  ITCM_RAM_DW  instruction word.
- ext2itcm_cmd_valid  in  1  loader write valid.
- ext2itcm_cmd_ready  out  1  loader write accepted.
- ext2itcm_cmd_addr  in  ITCM_ADDR_WIDTH  loader byte address.
- ext2itcm_cmd_wdata  in  ITCM_RAM_DW  write data.
- ext2itcm_cmd_wmask  in  ITCM_RAM_DW/8  byte enables.
- itcm_ram_cs  out  1  SRAM chip select.
- itcm_ram_we  out  1  SRAM write enable.
- itcm_ram_addr  out  ITCM_RAM_AW  SRAM word address.
- itcm_ram_wem  out  ITCM_RAM_DW/8  SRAM byte write mask.
- itcm_ram_din  out  ITCM_RAM_DW  SRAM write data.
- itcm_ram_dout  in  ITCM_RAM_DW  SRAM read data, valid one cycle after a read.

Behaviour:
- State: rd_pend (a read was issued last cycle, so SRAM dout is live now); hold_vld and hold_data (captured word waiting for IFU).
- Reset (rst=1 at a clk edge): rd_pend=0, hold_vld=0, hold_data=0. Any in-flight read is dropped and produces no response. During and after reset: ifu2itcm_rsp_valid=0 and itcm_ram_cs=0.
- Address mapping: word address = addr[ITCM_ADDR_WIDTH-1:2]. Bits [1:0] are ignored; no error response is generated.
- Arbitration:
  - ext2itcm_cmd_ready = 1 always.
  - An ext write wins the SRAM whenever ext2itcm_cmd_valid=1.
  - Ext write drive: cs=1, we=1, wem=wmask, din=wdata. Completes in that cycle; no response.
- Fetch acceptance: ifu2itcm_cmd_ready = ~ext2itcm_cmd_valid & ~hold_vld & ~(rd_pend & ~ifu2itcm_rsp_ready).
- Fetch issue: on a handshake, drive cs=1, we=0, wem=0, addr=word address; set rd_pend=1 next cycle. Otherwise rd_pend=0 next cycle.
- Response mux:
  - ifu2itcm_rsp_valid = hold_vld | rd_pend.
  - ifu2itcm_rsp_rdata = hold_vld ? hold_data : itcm_ram_dout.
  - hold_vld and rd_pend are never both 1; the acceptance rule guarantees this, and verification asserts it.
- Back-pressure: if rd_pend=1 and rsp_ready=0, itcm_ram_dout is captured into hold_data and hold_vld=1 next cycle. hold_vld clears on the cycle it is consumed (rsp_ready=1).
- Latency: command handshake in cycle N, response valid in cycle N+1.
- Throughput: one fetch per cycle while rsp_ready=1 and no ext write.
- Simultaneous ext write and pending read: the pending word is still delivered in the same cycle or captured into hold. The SRAM write does not corrupt it.
- Response ordering is strictly in order. At most one response is outstanding or buffered.
- When the SRAM is idle: cs=0, we=0, wem=0. addr and din are don't-care but driven to 0.

Decomposition:
- Shared defines: ITCM_ADDR_WIDTH, ITCM_RAM_DW, ITCM_RAM_AW, already used by the IFU side.
- One natural sub-module: itcm_rsp_buf, the one-entry holding buffer (hold_vld/hold_data plus mux), reusable by a future DTCM controller.
- Arbitration and SRAM drive stay in itcm_ctrl.

Test Plan:
- Reset: hold rst=1 for 3 cycles with cmd_valid=1 -> rsp_valid=0, cs=0 throughout. First fetch after reset is accepted in the cycle rst is 0.
- Load then fetch: ext write addr 0x0004 data 0x00500093 wmask 0xF, then fetch 0x0004 -> rsp_valid one cycle later, rdata=0x00500093.
- Streaming: fetch 0x0000, 0x0004, 0x0008 back-to-back with rsp_ready=1 -> cmd_ready=1 each cycle; three in-order responses on consecutive cycles.
- Back-pressure: fetch 0x0008 with rsp_ready=0 for 4 cycles -> rsp_valid stays 1, rdata stable and correct, cmd_ready=0 until consumed, no second SRAM read issued.
- Collision: ext write to 0x0008 (data 0xDEADBEEF) in the cycle a prior read of 0x0008 returns -> old word delivered; a later fetch returns 0xDEADBEEF. cmd_ready=0 in the ext cycle.
- Mid-flight reset: assert rst in the cycle after a fetch handshake -> no response ever appears; hold_vld=0.
